// File: rtl/wmem_ctrl_pkg.sv
// Shared types for the weight-memory controller:
// FSM state encoding and command mode constants.
package wmem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FETCH,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam logic MODE_LOAD  = 1'b0;
    localparam logic MODE_FETCH = 1'b1;

endpackage

// File: rtl/wmem_ctrl.sv
// Weight-memory controller: loads row words into the weight memory and
// streams them back to the PE array, repeating the row range on request.
module wmem_ctrl
    import wmem_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ROW_NUM       = 6,
    parameter int ADDR_WIDTH    = 7,
    parameter int ROW_WGT_WIDTH = DATA_WIDTH * ROW_NUM,
    parameter int REP_WIDTH     = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_cfg_valid,
    input  logic                     i_cfg_mode,
    input  logic [ADDR_WIDTH-1:0]    i_cfg_base,
    input  logic [ADDR_WIDTH:0]      i_cfg_len,
    input  logic [REP_WIDTH-1:0]     i_cfg_rep,
    output logic                     o_cfg_ready,
    input  logic                     i_ld_valid,
    input  logic [ROW_WGT_WIDTH-1:0] i_ld_data,
    output logic                     o_ld_ready,
    output logic                     o_wr_en,
    output logic [ADDR_WIDTH-1:0]    o_wr_addr,
    output logic [ROW_WGT_WIDTH-1:0] o_wr_data,
    output logic                     o_rd_en,
    output logic [ADDR_WIDTH-1:0]    o_rd_addr,
    input  logic [ROW_WGT_WIDTH-1:0] i_rd_data,
    output logic                     o_wgt_valid,
    output logic [ROW_WGT_WIDTH-1:0] o_wgt_data,
    input  logic                     i_wgt_stall,
    output logic                     o_done
);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [ADDR_WIDTH:0]     len_q, len_d;
    logic [ADDR_WIDTH:0]     off_q, off_d;
    logic [REP_WIDTH-1:0]    rep_q, rep_d;
    logic [REP_WIDTH-1:0]    pass_q, pass_d;
    logic                    vld_q, vld_d;

    logic [ADDR_WIDTH:0]     off_inc;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    consume;

    // Address wraps naturally modulo 2^ADDR_WIDTH
    assign off_inc = off_q + (ADDR_WIDTH+1)'(1);
    assign addr    = base_q + off_q[ADDR_WIDTH-1:0];
    assign consume = vld_q & ~i_wgt_stall;

    assign o_wr_addr   = addr;
    assign o_rd_addr   = addr;
    assign o_wr_data   = i_ld_data;
    assign o_wgt_data  = i_rd_data;
    assign o_wgt_valid = vld_q;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        rep_d       = rep_q;
        off_d       = off_q;
        pass_d      = pass_q;
        vld_d       = consume ? 1'b0 : vld_q;
        o_cfg_ready = 1'b0;
        o_ld_ready  = 1'b0;
        o_wr_en     = 1'b0;
        o_rd_en     = 1'b0;
        o_done      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                o_cfg_ready = 1'b1;
                if (i_cfg_valid) begin
                    base_d = i_cfg_base;
                    len_d  = i_cfg_len;
                    rep_d  = i_cfg_rep;
                    off_d  = '0;
                    pass_d = '0;
                    if (i_cfg_len == '0)
                        state_d = ST_DONE;
                    else if (i_cfg_mode == MODE_FETCH)
                        state_d = ST_FETCH;
                    else
                        state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                o_ld_ready = 1'b1;
                if (i_ld_valid) begin
                    o_wr_en = 1'b1;
                    off_d   = off_inc;
                    if (off_inc == len_q)
                        state_d = ST_DONE;
                end
            end
            ST_FETCH: begin
                // A stall freezes the read address so the row stays stable
                if (!i_wgt_stall) begin
                    o_rd_en = 1'b1;
                    vld_d   = 1'b1;
                    if (off_inc == len_q) begin
                        off_d = '0;
                        if (pass_q == rep_q)
                            state_d = ST_DRAIN;
                        else
                            pass_d = pass_q + REP_WIDTH'(1);
                    end else begin
                        off_d = off_inc;
                    end
                end
            end
            ST_DRAIN: begin
                if (!vld_q || consume)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                o_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            rep_q   <= '0;
            off_q   <= '0;
            pass_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            rep_q   <= rep_d;
            off_q   <= off_d;
            pass_q  <= pass_d;
            vld_q   <= vld_d;
        end
    end

endmodule
